// File: rtl/nbcac_pkg.sv
// Shared NBCAC definitions: data/code widths, the per-wire weight table and the
// reference encoder used by both the 18-wire encoder and the decoder's self-check.
package nbcac_pkg;

   localparam int NBCAC_DATA_W = 13;
   localparam int NBCAC_CODE_W = 18;
   localparam int NBCAC_SUM_W  = 14;
   localparam int NBCAC_HALF_W = 9;

   // Fibonacci weights F(1)..F(17) on wires 1..17, F(19) on wire 18. Each weight is
   // at most one more than the sum of all lower weights, so greedy encoding is exact.
   localparam logic [NBCAC_DATA_W-1:0] NBCAC_W [NBCAC_CODE_W:1] = '{
      13'd4181, 13'd1597, 13'd987, 13'd610, 13'd377, 13'd233, 13'd144, 13'd89, 13'd55,
      13'd34,   13'd21,   13'd13,  13'd8,   13'd5,   13'd3,   13'd2,   13'd1,  13'd1
   };

   function automatic logic [NBCAC_CODE_W:1] nbcac_13di_encoder_core(
      input logic [NBCAC_DATA_W-1:0] data
   );
      logic [NBCAC_SUM_W-1:0]  rem;
      logic [NBCAC_CODE_W:1]   code;
      rem  = {1'b0, data};
      code = '0;
      for (int i = NBCAC_CODE_W; i >= 1; i--) begin
         if (rem >= {1'b0, NBCAC_W[i]}) begin
            code[i] = 1'b1;
            rem     = rem - {1'b0, NBCAC_W[i]};
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/nbcac_13di_decoder_core.sv
// Combinational weighted sum of a 9-wire slice of an NBCAC codeword; BASE selects
// which wires of the full codeword the slice represents (slice bit j = wire BASE+j+1).
module nbcac_13di_decoder_core
   import nbcac_pkg::*;
#(
   parameter int BASE = 0
) (
   input  logic [NBCAC_HALF_W-1:0] i_bits,
   output logic [NBCAC_SUM_W-1:0]  o_sum
);

   always_comb begin
      o_sum = '0;
      for (int j = 0; j < NBCAC_HALF_W; j++) begin
         if (i_bits[j]) begin
            o_sum = o_sum + {1'b0, NBCAC_W[BASE + j + 1]};
         end
      end
   end

endmodule

// File: rtl/nbcac_decoder_18.sv
// Two-stage pipelined 18-wire NBCAC decoder with overflow flag and saturating error count.
// Define NBCAC_DEC_CHECK_EN to add re-encode checking of every decoded word.
module nbcac_decoder_18
   import nbcac_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                    clock,
   input  logic                    rst,
   input  logic [NBCAC_CODE_W:1]   codein,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [NBCAC_DATA_W-1:0] dataout,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    code_err,
   output logic [ERR_CNT_W-1:0]    err_cnt
);

   // Handshake: a word moves across a port on a rising edge where valid && ready;
   // valid never depends on ready, and held data stays stable until it transfers.
   logic                   r_s1_valid;
   logic [NBCAC_SUM_W-1:0] r_s1_lo;
   logic [NBCAC_SUM_W-1:0] r_s1_hi;
   logic                   r_s2_valid;
   logic [NBCAC_SUM_W-1:0] r_s2_sum;

   logic [NBCAC_SUM_W-1:0] w_lo_sum;
   logic [NBCAC_SUM_W-1:0] w_hi_sum;
   logic                   w_out_xfer;
   logic                   w_s2_load;
   logic                   w_ovf;

   nbcac_13di_decoder_core #(.BASE(0)) u_core_lo (
      .i_bits (codein[NBCAC_HALF_W:1]),
      .o_sum  (w_lo_sum)
   );

   nbcac_13di_decoder_core #(.BASE(NBCAC_HALF_W)) u_core_hi (
      .i_bits (codein[NBCAC_CODE_W:NBCAC_HALF_W+1]),
      .o_sum  (w_hi_sum)
   );

   assign w_out_xfer = r_s2_valid && out_ready;
   assign w_s2_load  = !r_s2_valid || w_out_xfer;
   assign in_ready   = !r_s1_valid || w_s2_load;
   assign out_valid  = r_s2_valid;
   assign dataout    = r_s2_sum[NBCAC_DATA_W-1:0];
   assign w_ovf      = r_s2_sum[NBCAC_SUM_W-1];

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_lo    <= '0;
         r_s1_hi    <= '0;
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_lo <= w_lo_sum;
            r_s1_hi <= w_hi_sum;
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_sum   <= '0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_sum <= r_s1_lo + r_s1_hi;
         end
      end
   end

`ifdef NBCAC_DEC_CHECK_EN
   logic [NBCAC_CODE_W:1] r_s1_code;
   logic [NBCAC_CODE_W:1] r_s2_code;
   logic [NBCAC_CODE_W:1] w_reenc;
   logic [ERR_CNT_W-1:0]  r_err_cnt;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_s1_code <= '0;
         r_s2_code <= '0;
      end else begin
         if (in_ready && in_valid) begin
            r_s1_code <= codein;
         end
         if (w_s2_load && r_s1_valid) begin
            r_s2_code <= r_s1_code;
         end
      end
   end

   // A non-canonical codeword decodes to a value whose canonical encoding differs.
   assign w_reenc  = nbcac_13di_encoder_core(r_s2_sum[NBCAC_DATA_W-1:0]);
   assign code_err = w_ovf || (w_reenc != r_s2_code);

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (w_out_xfer && code_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign err_cnt = r_err_cnt;
`else
   assign code_err = w_ovf;
   assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_nbcac_decoder_18.sv
// Bench for nbcac_decoder_18: randomized words against an arithmetic reference model,
// expected results queued by the driver and consumed by an output monitor.
module tb_nbcac_decoder_18;

   localparam int ERR_CNT_W = 8;
   localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;
`ifdef NBCAC_DEC_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic                 clock = 1'b0;
   logic                 rst;
   logic [18:1]          codein;
   logic                 in_valid;
   logic                 in_ready;
   logic [12:0]          dataout;
   logic                 out_valid;
   logic                 out_ready;
   logic                 code_err;
   logic [ERR_CNT_W-1:0] err_cnt;

   always #5 clock = ~clock;

   nbcac_decoder_18 #(.ERR_CNT_W(ERR_CNT_W)) dut (
      .clock     (clock),
      .rst       (rst),
      .codein    (codein),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dataout   (dataout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .code_err  (code_err),
      .err_cnt   (err_cnt)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [13:0] exp_q[$];
   int          tb_w[1:18];
   int          exp_cnt = 0;
   int          n_xfer = 0;
   int          n_acc = 0;
   bit          bp_rand = 1'b0;
   logic        prev_hold;
   logic [12:0] prev_data;
   logic        prev_err;
   logic [13:0] mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Canonical codeword: take the heaviest wire whose weight still fits, repeat.
   function automatic logic [18:1] tb_encode(input int value);
      logic [18:1] c;
      int          x;
      c = '0;
      x = value;
      for (int k = 18; k >= 1; k--) begin
         if (x >= tb_w[k]) begin
            c[k] = 1'b1;
            x    = x - tb_w[k];
         end
      end
      return c;
   endfunction

   // Returns {code_err, dataout} the decoder must present for codeword c.
   function automatic logic [13:0] tb_expect(input logic [18:1] c);
      int          s;
      int          d;
      logic        err;
      logic [12:0] d13;
      s = 0;
      for (int k = 1; k <= 18; k++) if (c[k]) s = s + tb_w[k];
      d   = s % 8192;
      d13 = d[12:0];
      err = (s >= 8192);
      if (CHK_EN && (tb_encode(d) != c)) err = 1'b1;
      return {err, d13};
   endfunction

   task automatic send(input logic [18:1] c, output int waits);
      waits    = 0;
      codein   = c;
      in_valid = 1'b1;
      #1;
      while (!in_ready && waits < 100) begin
         @(negedge clock);
         #1;
         waits++;
      end
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: in_ready stuck at %0d, required 1", in_ready);
      end else begin
         exp_q.push_back(tb_expect(c));
         n_acc++;
      end
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic drain(output int cycles);
      cycles = 0;
      while (exp_q.size() != 0 && cycles < 500) begin
         @(negedge clock);
         cycles++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
      end
   endtask

   // Output monitor: samples mid-cycle, ahead of the edge where a transfer happens.
   initial begin
      prev_hold = 1'b0;
      forever begin
         @(negedge clock);
         #2;
         if (rst) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_data", dataout, prev_data);
               chk("hold_err", code_err, prev_err);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL spurious_output: dataout %0d with nothing expected", dataout);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("dataout", dataout, mon_e[12:0]);
                  chk("code_err", code_err, mon_e[13]);
                  chk("err_cnt", err_cnt, exp_cnt);
                  n_xfer++;
                  if (CHK_EN && mon_e[13] && exp_cnt < CNT_MAX) exp_cnt++;
               end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = dataout;
            prev_err  = code_err;
         end
      end
   end

   always @(negedge clock) begin
      if (bp_rand) out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #1000000;
      n_errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      int          w;
      int          stalls;
      int          dc;
      int          d;
      int          xfer0;
      logic [12:0] rt_vals[4];
      logic [18:1] c;

      tb_w[1] = 1;
      tb_w[2] = 1;
      for (int k = 3; k <= 17; k++) tb_w[k] = tb_w[k-1] + tb_w[k-2];
      tb_w[18] = tb_w[17] + tb_w[16] + tb_w[17];

      rst       = 1'b1;
      in_valid  = 1'b0;
      codein    = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clock);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_dataout", dataout, 0);
      chk("rst_code_err", code_err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      @(negedge clock);

      // Round trip with two-cycle latency
      rt_vals[0] = 13'h0000;
      rt_vals[1] = 13'h1FFF;
      rt_vals[2] = 13'h0AAA;
      rt_vals[3] = 13'h1555;
      for (int i = 0; i < 4; i++) begin
         send(tb_encode(int'(rt_vals[i])), w);
         #1;
         chk("lat_cycle1_valid", out_valid, 0);
         @(negedge clock);
         #1;
         chk("lat_cycle2_valid", out_valid, 1);
         chk("rt_data", dataout, rt_vals[i]);
         chk("rt_code_err", code_err, 0);
         @(negedge clock);
      end

      // Streaming, one word per cycle
      stalls = 0;
      xfer0  = n_xfer;
      for (int i = 0; i < 1000; i++) begin
         d = int'($urandom_range(0, 8191));
         send(tb_encode(d), w);
         stalls = stalls + w;
      end
      drain(dc);
      chk("stream_stalls", stalls, 0);
      chk("stream_tail_cycles", dc, 2);
      chk("stream_count", n_xfer - xfer0, 1000);

      // Backpressure
      out_ready = 1'b0;
      send(tb_encode(int'($urandom_range(0, 8191))), w);
      send(tb_encode(int'($urandom_range(0, 8191))), w);
      #1;
      chk("bp_in_ready", in_ready, 0);
      repeat (4) @(negedge clock);
      out_ready = 1'b1;
      send(tb_encode(int'($urandom_range(0, 8191))), w);
      send(tb_encode(int'($urandom_range(0, 8191))), w);
      drain(dc);
      chk("exactly_once", n_xfer, n_acc);

      // Overflow on the all-ones codeword
      send(18'h3FFFF, w);
      @(negedge clock);
      #1;
      chk("ovf_valid", out_valid, 1);
      chk("ovf_code_err", code_err, 1);
      @(negedge clock);

      // Arbitrary raw codewords under random backpressure
      bp_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
         c = 18'($urandom);
         if (i % 50 == 0) c = 18'h3FFFF;
         send(c, w);
      end
      bp_rand   = 1'b0;
      out_ready = 1'b1;
      drain(dc);
      chk("raw_exactly_once", n_xfer, n_acc);

      // Reset with both stages full
      out_ready = 1'b0;
      send(tb_encode(int'($urandom_range(0, 8191))), w);
      send(tb_encode(int'($urandom_range(0, 8191))), w);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_err_cnt", err_cnt, 0);
      chk("midrst_dataout", dataout, 0);
      exp_q.delete();
      exp_cnt = 0;
      n_acc   = n_xfer;
      @(negedge clock);
      rst       = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      @(negedge clock);
      d = int'($urandom_range(0, 8191));
      send(tb_encode(d), w);
      @(negedge clock);
      #1;
      chk("postrst_valid", out_valid, 1);
      chk("postrst_data", dataout, d);
      @(negedge clock);
      drain(dc);

      // Corrupted codeword: 13'h0001 with wire 1 flipped
      c    = tb_encode(1);
      c[1] = ~c[1];
      send(c, w);
      #1;
      chk("flip_err_cnt_before", err_cnt, 0);
      @(negedge clock);
      #1;
      chk("flip_code_err", code_err, CHK_EN ? 1 : 0);
      @(negedge clock);
      #1;
      chk("flip_err_cnt_after", err_cnt, CHK_EN ? 1 : 0);
      @(negedge clock);

      // Saturation of the error counter
      for (int i = 0; i < 300; i++) begin
         c    = tb_encode(int'($urandom_range(0, 8191)));
         c[1] = ~c[1];
         send(c, w);
      end
      drain(dc);
      @(negedge clock);
      #1;
      chk("err_cnt_sat", err_cnt, CHK_EN ? CNT_MAX : 0);
      chk("final_exactly_once", n_xfer, n_acc);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
